// File: rtl/upower_alu_64b.sv
// upower_alu_64b: registered 64-bit execute stage for the uPower datapath.
// The ALU control decoder and the 64-bit ALU are combinational.
// The result, the flags and the decoded control are captured on the
// rising clock edge, so the stage has one cycle of latency.
module upower_alu_64b (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  po,
  input  logic [8:0]  xo,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output logic        overflow,
  output logic        carry_out,
  output logic        zero,
  output logic [3:0]  alu_ctrl,
  output logic        illegal
);

  typedef enum logic [3:0] {
    CTRL_AND  = 4'b0000,
    CTRL_OR   = 4'b0001,
    CTRL_ADD  = 4'b0010,
    CTRL_XOR  = 4'b0011,
    CTRL_SUB  = 4'b0110,
    CTRL_SLT  = 4'b0111,
    CTRL_NOR  = 4'b1100,
    CTRL_NAND = 4'b1101
  } alu_ctrl_e;

  alu_ctrl_e   w_ctrl;
  logic        w_illegal;
  logic [64:0] w_sum;
  logic [64:0] w_diff;
  logic [63:0] w_res;
  logic        w_ovf;
  logic        w_cry;

  logic [63:0] r_result;
  logic        r_overflow;
  logic        r_carry;
  logic        r_zero;
  logic [3:0]  r_alu_ctrl;
  logic        r_illegal;

  // Bit 64 of the difference is the CA bit: it is set exactly when a >= b (unsigned).
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + 65'd1;

  // Decode alu_op/po/xo into an ALU control code and flag undecodable pairs.
  always_comb begin
    w_ctrl    = CTRL_ADD;
    w_illegal = 1'b0;
    unique case (alu_op)
      2'b00: w_ctrl = CTRL_ADD;
      2'b01: w_ctrl = CTRL_SUB;
      2'b11: w_ctrl = CTRL_SLT;
      default: begin
        if (po == 6'd31) begin
          case (xo)
            9'd266:  w_ctrl = CTRL_ADD;
            9'd40:   w_ctrl = CTRL_SUB;
            9'd0:    w_ctrl = CTRL_SUB;
            9'd28:   w_ctrl = CTRL_AND;
            9'd444:  w_ctrl = CTRL_OR;
            9'd316:  w_ctrl = CTRL_XOR;
            9'd124:  w_ctrl = CTRL_NOR;
            9'd476:  w_ctrl = CTRL_NAND;
            default: w_illegal = 1'b1;
          endcase
        end else begin
          case (po)
            6'd14:   w_ctrl = CTRL_ADD;
            6'd28:   w_ctrl = CTRL_AND;
            6'd24:   w_ctrl = CTRL_OR;
            6'd26:   w_ctrl = CTRL_XOR;
            default: w_illegal = 1'b1;
          endcase
        end
      end
    endcase
  end

  // Compute the selected operation's result and its overflow/carry flags.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_cry = 1'b0;
    case (w_ctrl)
      CTRL_ADD: begin
        w_res = w_sum[63:0];
        w_cry = w_sum[64];
        w_ovf = (a[63] == b[63]) && (w_sum[63] != a[63]);
      end
      CTRL_SUB: begin
        w_res = w_diff[63:0];
        w_cry = w_diff[64];
        w_ovf = (a[63] != b[63]) && (w_diff[63] != a[63]);
      end
      CTRL_SLT:  w_res = {63'd0, ($signed(a) < $signed(b))};
      CTRL_AND:  w_res = a & b;
      CTRL_OR:   w_res = a | b;
      CTRL_XOR:  w_res = a ^ b;
      CTRL_NOR:  w_res = ~(a | b);
      CTRL_NAND: w_res = ~(a & b);
      default:   w_res = '0;
    endcase
  end

  // Output stage: reset clears the outputs, en captures them, otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b1;
      r_alu_ctrl <= '0;
      r_illegal  <= 1'b0;
    end else if (en) begin
      r_result   <= w_res;
      r_overflow <= w_ovf;
      r_carry    <= w_cry;
      r_zero     <= (w_res == '0);
      r_alu_ctrl <= w_ctrl;
      r_illegal  <= w_illegal;
    end
  end

  assign result    = r_result;
  assign overflow  = r_overflow;
  assign carry_out = r_carry;
  assign zero      = r_zero;
  assign alu_ctrl  = r_alu_ctrl;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_upower_alu_64b.sv
// Testbench for upower_alu_64b.
// The driver pushes one expected output tuple per clock edge.
// The monitor pops that tuple after the edge and compares it with the outputs.
module tb_upower_alu_64b;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  alu_op;
  logic [5:0]  po;
  logic [8:0]  xo;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] result;
  logic        overflow;
  logic        carry_out;
  logic        zero;
  logic [3:0]  alu_ctrl;
  logic        illegal;

  typedef struct {
    logic [63:0] res;
    logic        v;
    logic        c;
    logic        z;
    logic [3:0]  ctrl;
    logic        ill;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT  = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] NPAT = 64'hF0F0_F0F0_F0F0_F0F0;

  upower_alu_64b dut (
    .clk(clk), .rst(rst), .en(en), .alu_op(alu_op), .po(po), .xo(xo),
    .a(a), .b(b), .result(result), .overflow(overflow), .carry_out(carry_out),
    .zero(zero), .alu_ctrl(alu_ctrl), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t reset_exp();
    exp_t e;
    e.res = '0; e.v = 1'b0; e.c = 1'b0; e.z = 1'b1; e.ctrl = 4'b0000; e.ill = 1'b0;
    e.name = "reset";
    return e;
  endfunction

  // Reference model: the operation table plus plain signed/unsigned arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] p,
                                 input logic [8:0] x, input logic [63:0] ia,
                                 input logic [63:0] ib);
    exp_t   e;
    longint sa, sb, sr;
    int     pi, xi;
    pi = int'(p);
    xi = int'(x);
    e.ill  = 1'b0;
    e.ctrl = 4'b0010;
    if (op == 2'd0)      e.ctrl = 4'b0010;
    else if (op == 2'd1) e.ctrl = 4'b0110;
    else if (op == 2'd3) e.ctrl = 4'b0111;
    else if (pi == 31) begin
      if (xi == 266)                e.ctrl = 4'b0010;
      else if (xi == 40 || xi == 0) e.ctrl = 4'b0110;
      else if (xi == 28)            e.ctrl = 4'b0000;
      else if (xi == 444)           e.ctrl = 4'b0001;
      else if (xi == 316)           e.ctrl = 4'b0011;
      else if (xi == 124)           e.ctrl = 4'b1100;
      else if (xi == 476)           e.ctrl = 4'b1101;
      else                          e.ill  = 1'b1;
    end else begin
      if (pi == 14)      e.ctrl = 4'b0010;
      else if (pi == 28) e.ctrl = 4'b0000;
      else if (pi == 24) e.ctrl = 4'b0001;
      else if (pi == 26) e.ctrl = 4'b0011;
      else               e.ill  = 1'b1;
    end
    sa  = ia;
    sb  = ib;
    e.v = 1'b0;
    e.c = 1'b0;
    case (e.ctrl)
      4'b0010: begin
        e.res = ia + ib;
        sr    = e.res;
        e.c   = (e.res < ia);
        e.v   = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
      end
      4'b0110: begin
        e.res = ia - ib;
        sr    = e.res;
        e.c   = (ia >= ib);
        e.v   = (sa >= 0 && sb < 0 && sr < 0) || (sa < 0 && sb >= 0 && sr >= 0);
      end
      4'b0111: e.res = (sa < sb) ? 64'd1 : 64'd0;
      4'b0000: e.res = ia & ib;
      4'b0001: e.res = ia | ib;
      4'b0011: e.res = ia ^ ib;
      4'b1100: e.res = ~(ia | ib);
      default: e.res = ~(ia & ib);
    endcase
    e.z = (e.res == 64'd0);
    return e;
  endfunction

  task automatic apply(input logic r, input logic e, input logic [1:0] op,
                       input logic [5:0] p, input logic [8:0] x,
                       input logic [63:0] ia, input logic [63:0] ib);
    @(negedge clk);
    rst = r; en = e; alu_op = op; po = p; xo = x; a = ia; b = ib;
  endtask

  // Drive one cycle with the expected outputs taken from the reference model.
  task automatic drive(input logic r, input logic e, input logic [1:0] op,
                       input logic [5:0] p, input logic [8:0] x,
                       input logic [63:0] ia, input logic [63:0] ib, input string nm);
    exp_t ex;
    apply(r, e, op, p, x, ia, ib);
    if (r)       ex = reset_exp();
    else if (!e) ex = last;
    else         ex = model(op, p, x, ia, ib);
    ex.name = nm;
    last = ex;
    q.push_back(ex);
  endtask

  // Drive one cycle with hand-written expected outputs.
  task automatic drive_k(input logic [1:0] op, input logic [5:0] p, input logic [8:0] x,
                         input logic [63:0] ia, input logic [63:0] ib,
                         input logic [63:0] er, input logic [3:0] ec, input logic ecy,
                         input logic ev, input logic eil, input string nm);
    exp_t ex;
    apply(1'b0, 1'b1, op, p, x, ia, ib);
    ex.res = er; ex.ctrl = ec; ex.c = ecy; ex.v = ev; ex.ill = eil;
    ex.z = (er == 64'd0); ex.name = nm;
    last = ex;
    q.push_back(ex);
  endtask

  // Monitor: after every rising edge compare the outputs with the next expected tuple.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        n_tests++;
        if (result !== ex.res || overflow !== ex.v || carry_out !== ex.c ||
            zero !== ex.z || alu_ctrl !== ex.ctrl || illegal !== ex.ill) begin
          n_fail++;
          $display("FAIL %s: got res=%h v=%b c=%b z=%b ctrl=%b ill=%b, exp res=%h v=%b c=%b z=%b ctrl=%b ill=%b",
                   ex.name, result, overflow, carry_out, zero, alu_ctrl, illegal,
                   ex.res, ex.v, ex.c, ex.z, ex.ctrl, ex.ill);
        end
      end
    end
  end

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = ALL1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h7FFF_FFFF_FFFF_FFFF;
      4: v = 64'({$urandom_range(0, 3)});
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    int          xo_tab[9];
    int          po_tab[6];
    logic [5:0]  rp;
    logic [8:0]  rx;
    logic [63:0] ra, rb;
    int          budget;
    xo_tab = '{266, 40, 0, 28, 444, 316, 124, 476, 7};
    po_tab = '{31, 31, 14, 28, 24, 26};
    rst = 1'b1; en = 1'b0; alu_op = '0; po = '0; xo = '0; a = '0; b = '0;
    last = reset_exp();

    // Reset for two cycles with random inputs and en high.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'b1, 2'($urandom), 6'($urandom), 9'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, "reset_hold");

    drive_k(2'b10, 6'd31, 9'd266, 64'd5, 64'd3, 64'd8, 4'b0010, 1'b0, 1'b0, 1'b0, "add_5_3");
    drive_k(2'b10, 6'd31, 9'd266, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
            64'h8000_0000_0000_0000, 4'b0010, 1'b0, 1'b1, 1'b0, "add_ovf");
    drive_k(2'b10, 6'd31, 9'd40, 64'd10, 64'd3, 64'd7, 4'b0110, 1'b1, 1'b0, 1'b0, "subf_10_3");
    drive_k(2'b10, 6'd31, 9'd40, 64'h1234, 64'h1234, 64'd0, 4'b0110, 1'b1, 1'b0, 1'b0, "subf_eq");
    drive_k(2'b10, 6'd31, 9'd0, 64'd0, 64'd1, ALL1, 4'b0110, 1'b0, 1'b0, 1'b0, "cmp_0_1");
    drive_k(2'b10, 6'd31, 9'd476, ALL1, PAT, NPAT, 4'b1101, 1'b0, 1'b0, 1'b0, "nand");
    drive_k(2'b10, 6'd31, 9'd316, ALL1, PAT, NPAT, 4'b0011, 1'b0, 1'b0, 1'b0, "xor");
    drive_k(2'b10, 6'd31, 9'd124, ALL1, PAT, 64'd0, 4'b1100, 1'b0, 1'b0, 1'b0, "nor");
    drive_k(2'b11, 6'd0, 9'd0, ALL1, 64'd1, 64'd1, 4'b0111, 1'b0, 1'b0, 1'b0, "slt_m1_1");
    drive_k(2'b10, 6'd31, 9'd7, 64'd2, 64'd3, 64'd5, 4'b0010, 1'b0, 1'b0, 1'b1, "illegal_xo7");
    drive_k(2'b00, 6'd31, 9'd40, ALL1, 64'd1, 64'd0, 4'b0010, 1'b1, 1'b0, 1'b0, "ldst_add_carry");

    // Load a result, hold with en low while the inputs change, then reset while en is low.
    drive_k(2'b10, 6'd31, 9'd266, 64'd5, 64'd3, 64'd8, 4'b0010, 1'b0, 1'b0, 1'b0, "load_for_hold");
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 2'($urandom), 6'($urandom), 9'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, "hold_en0");
    drive(1'b1, 1'b0, 2'b10, 6'd31, 9'd266, 64'd5, 64'd3, "rst_while_en0");
    drive(1'b0, 1'b1, 2'b01, 6'd0, 9'd0, 64'd9, 64'd4, "first_after_rst");

    // Random traffic with occasional enable drops and resets.
    for (int i = 0; i < 400; i++) begin
      rp = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(po_tab[$urandom_range(0, 5)]);
      rx = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'(xo_tab[$urandom_range(0, 8)]);
      ra = rand_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_operand();
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
            2'($urandom), rp, rx, ra, rb, "random");
    end

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected outputs still queued, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
